// File: rtl/rv16_pkg.sv
// Shared RV16 definitions: core widths, the fetch queue entry and the fetch FSM states.
package rv16_pkg;

  localparam int          RV16_XLEN     = 16;
  localparam logic [15:0] RV16_NOP      = 16'h0000;
  localparam logic [15:0] RV16_PC_LIMIT = 16'h0fff;

  typedef struct packed {
    logic [RV16_XLEN-1:0] inst;
    logic [RV16_XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1
`ifdef RV16_FETCH_PC_CLAMP_EN
    , ST_HOLD = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/rv16_fetch_fifo.sv
// Synchronous FIFO with flush and a registered head; an empty FIFO presents all zeros.
// Used both as the instruction queue and as the tag queue of issued addresses.
import rv16_pkg::*;

module rv16_fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  // Storage array: written on push, no reset needed since the head is gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // The credit scheme upstream must never push into a full queue without a pop.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && !do_pop && count == DEPTH_W));
  end

endmodule

// File: rtl/rv16_fetch_unit.sv
// RV16 instruction fetch front end: credit-limited request issue, in-order response
// buffering with PC tags, and wrong-path discard on redirect.
// Optional feature macro RV16_FETCH_PC_CLAMP_EN: stop fetching after PC_LIMIT is requested.
import rv16_pkg::*;

module rv16_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_LIMIT = RV16_PC_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t         state, state_next;
  logic [15:0]          fetch_pc;
  logic [CW-1:0]        outstanding, discard, q_count, tag_count;
  logic [CW:0]          credit_used;
  logic                 pc_ok, req_fire, rsp_keep;
  fetch_entry_t         q_head, q_in;
  logic [RV16_XLEN-1:0] tag_head;

`ifdef RV16_FETCH_PC_CLAMP_EN
  assign pc_ok = (fetch_pc <= PC_LIMIT);
`else
  assign pc_ok = 1'b1;
`endif

  // Queued entries plus in-flight requests (including ones to be discarded) bound issue.
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = (state == ST_RUN) && pc_ok && (credit_used < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (discard == '0) && !redirect_valid;

  assign q_in.inst  = imem_rsp_data;
  assign q_in.pc    = tag_head;
  assign inst_valid = (q_count != '0);
  assign inst_data  = inst_valid ? q_head.inst : RV16_NOP;
  assign inst_pc    = q_head.pc;

  rv16_fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data_q (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(rsp_keep), .push_data(q_in), .pop(inst_valid && inst_ready),
    .head(q_head), .count(q_count)
  );

  rv16_fetch_fifo #(.DEPTH(DEPTH), .T(logic [RV16_XLEN-1:0])) u_tag_q (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(req_fire), .push_data(fetch_pc), .pop(rsp_keep),
    .head(tag_head), .count(tag_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_next;
  end

  // FSM next state: leave reset immediately, park in HOLD at the clamp limit.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_RUN;
`ifdef RV16_FETCH_PC_CLAMP_EN
      ST_RUN:   if (!redirect_valid && (!pc_ok || (req_fire && fetch_pc == PC_LIMIT)))
                  state_next = ST_HOLD;
      ST_HOLD:  if (redirect_valid) state_next = ST_RUN;
`else
      ST_RUN:   state_next = ST_RUN;
`endif
      default:  state_next = ST_RESET;
    endcase
  end

  // Fetch PC, in-flight count and wrong-path discard count; redirect overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        discard  <= outstanding - CW'(imem_rsp_valid) + CW'(req_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 16'd1;
        if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
      end
    end
  end

  // A kept response must always have a matching issued address in the tag queue.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(rsp_keep && tag_count == '0));
  end

endmodule

// File: tb/tb_rv16_fetch_unit.sv
// Randomized bench for rv16_fetch_unit. The memory is a latency queue; the reference
// model is the architectural stream: after reset or a redirect to P, requests and
// delivered instructions must be P, P+1, ... with data equal to the memory contents.
module tb_rv16_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;

  rv16_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rdy_rand = 1'b0;
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  logic [15:0] exp_pc = '0;
  logic [15:0] req_exp = '0;
  int          delivered = 0;
  int          hs_cnt = 0;
  bit          hold_prev = 1'b0;
  logic [15:0] prev_pc, prev_data;
  bit          got_first = 1'b0;
  logic [15:0] first_pc = '0;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a * 16'h9e37) ^ 16'h5a5a;
  endfunction

  // One clock cycle: memory drives its response, then the stream model checks the DUT.
  task automatic cycle();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(mq_addr[0]);
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (!rst) begin
      if (hold_prev) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== prev_pc || inst_data !== prev_data)
          $display("FAIL stall_stable: got v=%b pc=%h d=%h, want v=1 pc=%h d=%h",
                   inst_valid, inst_pc, inst_data, prev_pc, prev_data);
        else passes++;
      end
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) $display("FAIL no_req_on_redirect: got %b want 0", imem_req_valid);
        else passes++;
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== req_exp) $display("FAIL req_addr: got %h want %h", imem_req_addr, req_exp);
        else passes++;
        req_exp++;
        hs_cnt++;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        checks++;
        if (inst_pc !== exp_pc || inst_data !== mem_f(exp_pc))
          $display("FAIL inst_stream: got pc=%h d=%h want pc=%h d=%h",
                   inst_pc, inst_data, exp_pc, mem_f(exp_pc));
        else passes++;
        if (!got_first) begin first_pc = inst_pc; got_first = 1'b1; end
        exp_pc++;
        delivered++;
      end
      hold_prev = inst_valid && !inst_ready && !redirect_valid;
      prev_pc   = inst_pc;
      prev_data = inst_data;
      if (redirect_valid) begin
        exp_pc = redirect_pc; req_exp = redirect_pc; got_first = 1'b0;
      end
    end else begin
      mq_addr.delete(); mq_due.delete();
      exp_pc = '0; req_exp = '0; hold_prev = 1'b0; got_first = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; rdy_rand = 1'b0; inst_ready = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    delivered = 0; hs_cnt = 0;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    cycle();
    redirect_valid = 1'b0;
    delivered = 0; hs_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc} !== '0)
      $display("FAIL reset_outputs: got rv=%b ra=%h iv=%b id=%h ip=%h want all 0",
               imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL reset_release_idle: got %b want 0", imem_req_valid);
    else passes++;
    cycle();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000)
      $display("FAIL first_req: got v=%b a=%h want v=1 a=0000", imem_req_valid, imem_req_addr);
    else passes++;
  endtask

  task automatic test_stream();
    lat = 1; do_reset();
    repeat (40) cycle();
    checks++;
    if (delivered < 35) $display("FAIL stream_throughput: got %0d want >=35", delivered);
    else passes++;
  endtask

  task automatic test_stall();
    lat = 1; do_reset();
    inst_ready = 1'b0;
    repeat (10) cycle();
    checks++;
    if (hs_cnt != 4 || imem_req_valid !== 1'b0 || mq_due.size() != 0)
      $display("FAIL stall_fill: got hs=%0d rv=%b inflight=%0d want 4 0 0",
               hs_cnt, imem_req_valid, mq_due.size());
    else passes++;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0000)
      $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0000", inst_valid, inst_pc);
    else passes++;
    inst_ready = 1'b1;
    repeat (10) cycle();
    checks++;
    if (delivered < 4) $display("FAIL stall_drain: got %0d want >=4", delivered);
    else passes++;
  endtask

  task automatic test_redirect_latency3();
    lat = 3; do_reset();
    cycle(); cycle(); cycle();
    checks++;
    if (mq_due.size() != 2) $display("FAIL two_in_flight: got %0d want 2", mq_due.size());
    else passes++;
    do_redirect(16'h0040);
    repeat (20) cycle();
    checks++;
    if (!got_first || first_pc !== 16'h0040)
      $display("FAIL redirect_first_pc: got seen=%b pc=%h want pc=0040", got_first, first_pc);
    else passes++;
  endtask

  task automatic test_redirect_collide();
    bit hit;
    lat = 2; do_reset();
    repeat (8) cycle();
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (mq_due.size() > 0 && mq_due[0] == cyc) hit = 1'b1;
      else cycle();
    end
    checks++;
    if (!hit) $display("FAIL collide_setup: got no response slot want one within 10 cycles");
    else passes++;
    do_redirect(16'h1234);
    repeat (20) cycle();
    checks++;
    if (!got_first || first_pc !== 16'h1234 || delivered < 10)
      $display("FAIL collide_first_pc: got pc=%h n=%0d want pc=1234 n>=10", first_pc, delivered);
    else passes++;
  endtask

  task automatic test_random();
    int total;
    total = 0;
    for (int s = 0; s < 4; s++) begin
      lat = $urandom_range(1, 4); do_reset(); rdy_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
        inst_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 39) == 0) begin
          total += delivered;
          do_redirect(16'($urandom_range(0, 16'h0f00)));
        end else cycle();
      end
      total += delivered;
    end
    rdy_rand = 1'b0; inst_ready = 1'b1;
    checks++;
    if (total < 100) $display("FAIL random_progress: got %0d want >=100", total);
    else passes++;
  endtask

  task automatic test_reset_mid();
    lat = 2; do_reset();
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc} !== '0)
      $display("FAIL mid_reset_outputs: got rv=%b ra=%h iv=%b id=%h ip=%h want all 0",
               imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc);
    else passes++;
    rst = 1'b0; delivered = 0;
    cycle();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000)
      $display("FAIL mid_reset_first_req: got v=%b a=%h want v=1 a=0000", imem_req_valid, imem_req_addr);
    else passes++;
    repeat (10) cycle();
    checks++;
    if (delivered < 5) $display("FAIL mid_reset_resume: got %0d want >=5", delivered);
    else passes++;
  endtask

`ifdef RV16_FETCH_PC_CLAMP_EN
  task automatic test_clamp();
    lat = 1; do_reset();
    repeat (5) cycle();
    do_redirect(16'h0ffe);
    repeat (15) cycle();
    checks++;
    if (hs_cnt != 2 || delivered != 2 || imem_req_valid !== 1'b0)
      $display("FAIL clamp_stop: got hs=%0d n=%0d rv=%b want 2 2 0", hs_cnt, delivered, imem_req_valid);
    else passes++;
    do_redirect(16'h0000);
    repeat (10) cycle();
    checks++;
    if (hs_cnt < 4 || delivered < 4) $display("FAIL clamp_resume: got hs=%0d n=%0d want >=4", hs_cnt, delivered);
    else passes++;
  endtask
`else
  task automatic test_wrap();
    lat = 1; do_reset();
    repeat (5) cycle();
    do_redirect(16'hfffe);
    repeat (15) cycle();
    checks++;
    if (delivered < 6 || exp_pc >= 16'h0100)
      $display("FAIL pc_wrap: got n=%0d next=%h want n>=6 next<0100", delivered, exp_pc);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency3();
    test_redirect_collide();
    test_random();
    test_reset_mid();
`ifdef RV16_FETCH_PC_CLAMP_EN
    test_clamp();
`else
    test_wrap();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
